// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_RTYPE,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that wait on memReady and are therefore guarded by the timeout counter
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/op_classify.sv
// rtl/op_classify.sv - combinational opcode-to-class decoder
module op_classify
    import ctrl_pkg::*;
(
    input  logic [10:0] Op,
    output op_class_t   op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        if (Op == OP_LDUR) begin
            op_class = CLS_LDUR;
        end else if (Op == OP_STUR) begin
            op_class = CLS_STUR;
        end else if ((Op & MASK_CBZ) == OP_CBZ) begin
            op_class = CLS_CBZ;
        end else if ((Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR)) begin
            op_class = CLS_RTYPE;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath control FSM with memory-timeout guard
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        zero,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        iorD,
    output logic        reg2Loc,
    output logic        aluSrcA,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        regWrite,
    output logic        pcSrc,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  ALUOp,
    output logic        instrDone,
    output logic        illegalOp,
    output logic        memErr
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state;
    state_t     state_next;
    op_class_t  op_class;
    logic [7:0] wait_cnt;
    logic       in_wait;
    logic       timeout;

    op_classify u_classify (
        .Op       (Op),
        .op_class (op_class)
    );

    assign in_wait = is_wait_state(state);
    // Last tolerated low cycle; a memReady arriving here still completes normally
    assign timeout = in_wait && !memReady && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (!in_wait || memReady || (state_next != state)) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memErr <= 1'b0;
        end else if (timeout) begin
            memErr <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pcWrite    = 1'b0;
        irWrite    = 1'b0;
        iorD       = 1'b0;
        reg2Loc    = 1'b0;
        aluSrcA    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        pcSrc      = 1'b0;
        aluSrcB    = SRCB_REG;
        ALUOp      = ALUOP_ADD;
        instrDone  = 1'b0;
        illegalOp  = 1'b0;

        case (state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                // Reset parks the FSM here, but nothing may be latched while it is held
                irWrite = memReady && !reset;
                pcWrite = memReady && !reset;
                if (memReady) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                aluSrcB = SRCB_IMM_SH2;
                reg2Loc = (op_class == CLS_STUR) || (op_class == CLS_CBZ);
                case (op_class)
                    CLS_LDUR, CLS_STUR: state_next = S_MEMADR;
                    CLS_RTYPE:          state_next = S_EXEC;
                    CLS_CBZ:            state_next = S_BRANCH;
                    default: begin
                        illegalOp  = 1'b1;
                        instrDone  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = SRCB_IMM;
                reg2Loc    = (op_class == CLS_STUR);
                state_next = (op_class == CLS_STUR) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_MEMWB: begin
                regWrite   = 1'b1;
                memToReg   = 1'b1;
                instrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                reg2Loc  = 1'b1;
                if (memReady) begin
                    instrDone  = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_EXEC: begin
                aluSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                instrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                ALUOp      = ALUOP_PASSB;
                reg2Loc    = 1'b1;
                pcSrc      = 1'b1;
                pcWrite    = zero;
                instrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, 15, max consecutive memReady-low cycles tolerated in a memory state; range 1..255.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 Op  in  11  opcode field Instr[31:21] from the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 memReady  in  1  memory completes the current read or write this cycle.
REQ-007 pcWrite, irWrite, iorD, reg2Loc, aluSrcA, memRead, memWrite, memToReg, regWrite, pcSrc  out  1 each  datapath controls.
REQ-008 aluSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-009 ALUOp  out  2  00 = add, 01 = pass B (CBZ), 10 = funct-decoded.
REQ-010 instrDone  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-011 illegalOp  out  1  one-cycle pulse in DECODE for an unknown opcode.
REQ-012 memErr  out  1  sticky memory-timeout flag.

Function
REQ-013 Opcode classes: LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, and R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, HALT.
REQ-015 Outputs are Moore (state-only), except pcWrite/irWrite in FETCH and pcWrite in BRANCH; every control not listed for a state is 0.
REQ-016 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, ALUOp=00; irWrite=pcWrite=memReady; go to DECODE when memReady=1, else stay.
REQ-017 DECODE: aluSrcA=0, aluSrcB=11, ALUOp=00; reg2Loc=1 for STUR and CBZ.
REQ-018 DECODE transitions: LDUR/STUR -> MEMADR, R-type -> EXEC, CBZ -> BRANCH; unknown -> FETCH with illegalOp=1 and instrDone=1.
REQ-019 MEMADR: aluSrcA=1, aluSrcB=10, ALUOp=00, reg2Loc=1 for STUR; go to MEMRD for LDUR, MEMWR for STUR.
REQ-020 MEMRD: memRead=1, iorD=1; go to MEMWB on memReady, else stay.
REQ-021 MEMWB: regWrite=1, memToReg=1, instrDone=1; go to FETCH.
REQ-022 MEMWR: memWrite=1, iorD=1, reg2Loc=1; on memReady, instrDone=1 and go to FETCH.
REQ-023 EXEC: aluSrcA=1, aluSrcB=00, ALUOp=10; go to ALUWB.
REQ-024 ALUWB: regWrite=1, memToReg=0, instrDone=1; go to FETCH.
REQ-025 BRANCH: aluSrcA=1, aluSrcB=00, ALUOp=01, reg2Loc=1, pcSrc=1, pcWrite=zero, instrDone=1; go to FETCH.
REQ-026 Op is sampled only in DECODE and MEMADR; Op changes in other states have no effect.
REQ-027 Wait counter (8 bits): cleared on entry to FETCH/MEMRD/MEMWR and on memReady=1; increments each cycle in those states while memReady=0.
REQ-028 When the counter reaches WAIT_MAX with memReady still 0, the FSM goes to HALT and sets memErr=1 on that edge; memReady arriving on that exact cycle wins (normal transition, no error).
REQ-029 HALT: all controls 0, memErr held 1; exit only via reset.
REQ-030 Cycle counts with memReady always 1: R-type 4, LDUR 5, STUR 4, CBZ 3, illegal 2.

Reset
REQ-031 Reset asserted: state=FETCH, counter=0, memErr=0, with all outputs at their FETCH/memReady=0 values (memRead=1, others 0) while reset is held.
REQ-032 Reset asserted mid-instruction aborts it: memWrite/regWrite deassert without waiting for a clock edge, and no pending write completes.
REQ-033 After reset deasserts, the first rising edge evaluates FETCH normally.

Structure
REQ-034 Package ctrl_pkg holds the state enum, the opcode constants/masks, the ALUOp codes and the aluSrcB codes.
REQ-035 A combinational sub-module op_classify maps Op to the class {LDUR, STUR, CBZ, RTYPE, ILLEGAL}; the FSM uses only the class.

Verification
REQ-036 Reset; ADD (10001011000), memReady=1 -> FETCH, DECODE, EXEC, ALUWB; regWrite=1 only in cycle 4; instrDone in cycle 4.
REQ-037 LDUR with memReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with regWrite=1, memToReg=1; memErr=0.
REQ-038 CBZ (10110100101): zero=1 -> pcWrite=1, pcSrc=1 in BRANCH; zero=0 -> pcWrite=0; 3 cycles each.
REQ-039 WAIT_MAX=4, STUR with memReady stuck 0 -> HALT after 4 wait cycles, memErr=1 sticky, memWrite=0 in HALT; reset clears it.
REQ-040 Op=00000000000 -> illegalOp and instrDone pulse in DECODE, back to FETCH; reset asserted mid-MEMWR -> memWrite drops before the next edge, state FETCH.
